snn_mem_arbiter: RTL

Single-port access arbiter for the SNN neuron/weight register space, in the `clk_snn` domain between the SPI slave's strobe interface and the SNN core's memory requester. It captures one-cycle host strobes (`en`/`we`/`addr`/`data`) into a one-deep pending slot. It arbitrates that slot against a held core request and issues at most one access per cycle to the shared memory. Read data is returned to the owner: host read data is held stable for asynchronous sampling by the SPI shifter.

---
 rtl/snn_pkg.sv | 25 ++
 rtl/snn_arb_rr2.sv | 47 ++++
 rtl/snn_mem_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | snn_pkg : shared widths, memory map anchors and request type for SNN  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package snn_pkg;

   localparam int SNN_ADDR_WIDTH  = 9;
   localparam int SNN_DATA_WIDTH  = 32;

   localparam int SPIKE_OUT_BASE0 = 384;
   localparam int DONE_PIC_ADDR   = 448;

   // Requester slots of the two-way round-robin picker
   localparam int ARB_CORE_IDX    = 0;
   localparam int ARB_HOST_IDX    = 1;

   typedef struct packed {
      logic                      we;
      logic [SNN_ADDR_WIDTH-1:0] addr;
      logic [SNN_DATA_WIDTH-1:0] wdata;
   } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/snn_arb_rr2.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | snn_arb_rr2 : two-requester round-robin picker with last-winner ptr   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module snn_arb_rr2 #(
   parameter logic RESET_LAST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic       last_q;
   logic       last_d;
   logic [1:0] gnt;

   // last_q names the requester index granted most recently
   always_comb begin
      gnt    = 2'b00;
      last_d = last_q;
      case (req_i)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_q ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
      if (gnt[1]) begin
         last_d = 1'b1;
      end else if (gnt[0]) begin
         last_d = 1'b0;
      end
   end

   assign gnt_o = gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= RESET_LAST;
      end else begin
         last_q <= last_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/snn_mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | snn_mem_arbiter : host/core single-port memory arbiter, clk_snn domain|
// | Option macro SNN_ARB_OVF_DET_EN enables the sticky host_ovf_o flag.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module snn_mem_arbiter
   import snn_pkg::*;
#(
   parameter int ADDR_WIDTH = SNN_ADDR_WIDTH,
   parameter int DATA_WIDTH = SNN_DATA_WIDTH
) (
   input  logic                  clk_snn,
   input  logic                  rst_i,
   input  logic                  host_en_i,
   input  logic                  host_we_i,
   input  logic [ADDR_WIDTH-1:0] host_addr_i,
   input  logic [DATA_WIDTH-1:0] host_wdata_i,
   output logic [DATA_WIDTH-1:0] host_rdata_o,
   output logic                  host_busy_o,
   output logic                  host_ovf_o,
   input  logic                  ovf_clr_i,
   input  logic                  core_req_i,
   input  logic                  core_we_i,
   input  logic [ADDR_WIDTH-1:0] core_addr_i,
   input  logic [DATA_WIDTH-1:0] core_wdata_i,
   output logic                  core_gnt_o,
   output logic                  core_rvalid_o,
   output logic [DATA_WIDTH-1:0] core_rdata_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   logic                  slot_valid_q, slot_valid_d;
   logic                  slot_we_q,    slot_we_d;
   logic [ADDR_WIDTH-1:0] slot_addr_q,  slot_addr_d;
   logic [DATA_WIDTH-1:0] slot_wdata_q, slot_wdata_d;

   logic                  mem_en_q,     mem_en_d;
   logic                  mem_we_q,     mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
   logic                  tag_host_q,   tag_host_d;
   logic                  ret_valid_q,  ret_valid_d;
   logic                  ret_host_q,   ret_host_d;
   logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;

   logic [1:0] arb_req;
   logic [1:0] arb_gnt;
   logic       host_gnt;
   logic       core_gnt;
   logic       host_drop;

   always_comb begin
      arb_req               = 2'b00;
      arb_req[ARB_HOST_IDX] = slot_valid_q;
      arb_req[ARB_CORE_IDX] = core_req_i;
   end

   snn_arb_rr2 #(
      .RESET_LAST (1'b1)
   ) u_rr2 (
      .clk   (clk_snn),
      .rst   (rst_i),
      .req_i (arb_req),
      .gnt_o (arb_gnt)
   );

   assign host_gnt = arb_gnt[ARB_HOST_IDX];
   assign core_gnt = arb_gnt[ARB_CORE_IDX];
   assign host_drop = host_en_i & slot_valid_q & ~host_gnt;

   always_comb begin
      slot_valid_d = slot_valid_q;
      slot_we_d    = slot_we_q;
      slot_addr_d  = slot_addr_q;
      slot_wdata_d = slot_wdata_q;
      if (host_gnt) begin
         slot_valid_d = 1'b0;
      end
      // A slot being drained this cycle can take the next strobe directly
      if (host_en_i && (!slot_valid_q || host_gnt)) begin
         slot_valid_d = 1'b1;
         slot_we_d    = host_we_i;
         slot_addr_d  = host_addr_i;
         slot_wdata_d = host_wdata_i;
      end

      mem_en_d    = host_gnt | core_gnt;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      tag_host_d  = host_gnt;
      if (host_gnt) begin
         mem_we_d    = slot_we_q;
         mem_addr_d  = slot_addr_q;
         mem_wdata_d = slot_wdata_q;
      end else if (core_gnt) begin
         mem_we_d    = core_we_i;
         mem_addr_d  = core_addr_i;
         mem_wdata_d = core_wdata_i;
      end

      // Owner tag follows the access one stage behind mem_*, aligned with mem_rdata_i
      ret_valid_d  = mem_en_q & ~mem_we_q;
      ret_host_d   = tag_host_q;
      host_rdata_d = (ret_valid_q && ret_host_q) ? mem_rdata_i : host_rdata_q;
   end

   always_ff @(posedge clk_snn or posedge rst_i) begin
      if (rst_i) begin
         slot_valid_q <= 1'b0;
         slot_we_q    <= 1'b0;
         slot_addr_q  <= '0;
         slot_wdata_q <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         tag_host_q   <= 1'b0;
         ret_valid_q  <= 1'b0;
         ret_host_q   <= 1'b0;
         host_rdata_q <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         slot_we_q    <= slot_we_d;
         slot_addr_q  <= slot_addr_d;
         slot_wdata_q <= slot_wdata_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         tag_host_q   <= tag_host_d;
         ret_valid_q  <= ret_valid_d;
         ret_host_q   <= ret_host_d;
         host_rdata_q <= host_rdata_d;
      end
   end

`ifdef SNN_ARB_OVF_DET_EN
   logic ovf_q, ovf_d;

   // A drop in the same cycle as a clear wins, so no overflow goes unseen
   always_comb begin
      ovf_d = host_drop | (ovf_q & ~ovf_clr_i);
   end

   always_ff @(posedge clk_snn or posedge rst_i) begin
      if (rst_i) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign host_ovf_o = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_clr_i ^ host_drop;
   assign host_ovf_o = 1'b0;
`endif

   assign host_busy_o   = slot_valid_q;
   assign host_rdata_o  = host_rdata_q;
   assign core_gnt_o    = core_gnt;
   assign core_rvalid_o = ret_valid_q & ~ret_host_q;
   assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
   assign mem_en_o      = mem_en_q;
   assign mem_we_o      = mem_we_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_wdata_o   = mem_wdata_q;

endmodule
`default_nettype wire
